// File: rtl/an_sec_decoder_seq.sv
// Sequential AN-code single-error-correcting decoder: bit-serial remainder,
// then a walk over the +/-2^k residues to locate and remove one arithmetic weight error.
module an_sec_decoder_seq #(
    parameter int CW_W = 65,
    parameter int A    = 131,
    parameter int A_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CW_W-1:0]   in_cw,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CW_W-1:0]   out_cw,
    output logic [CW_W:0]     out_awe,
    output logic [A_W-1:0]    out_rem,
    output logic              out_err,
    output logic              out_uncorr
);

    localparam int CNT_W = (CW_W > 1) ? $clog2(CW_W) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CW_W - 1);
    localparam logic [A_W:0]     A_EXT = (A_W + 1)'(A);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REM,
        S_CHECK,
        S_SEARCH,
        S_CORR,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [CW_W-1:0]  rcv;
    logic [A_W-1:0]   r;
    logic [A_W-1:0]   p;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] k;
    logic [CW_W-1:0]  pow;
    logic             neg;

    logic [A_W:0]     t;
    logic [A_W:0]     p2;
    logic [A_W-1:0]   r_step;
    logic [A_W-1:0]   p_step;
    logic [A_W-1:0]   a_minus_p;
    logic             hit_pos;
    logic             hit_neg;
    logic [CW_W+1:0]  c;
    logic             c_bad;
    logic [CW_W:0]    awe_val;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    always_comb begin
        t         = {r, rcv[cnt]};
        r_step    = (t >= A_EXT) ? A_W'(t - A_EXT) : t[A_W-1:0];
        p2        = {p, 1'b0};
        p_step    = (p2 >= A_EXT) ? A_W'(p2 - A_EXT) : p2[A_W-1:0];
        a_minus_p = A_W'(A_EXT - {1'b0, p});
        hit_pos   = (p == r);
        hit_neg   = !hit_pos && (a_minus_p == r);
        // pow holds |AWE| = 2^k; the sign lives separately in neg
        c         = neg ? ({2'b00, rcv} + {2'b00, pow}) : ({2'b00, rcv} - {2'b00, pow});
        c_bad     = |c[CW_W+1:CW_W];
        awe_val   = neg ? (~{1'b0, pow} + 1'b1) : {1'b0, pow};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (in_valid) state_nx = S_REM;
            S_REM:    if (cnt == '0) state_nx = S_CHECK;
            S_CHECK:  state_nx = (r == '0) ? S_DONE : S_SEARCH;
            S_SEARCH: begin
                if (hit_pos || hit_neg) state_nx = S_CORR;
                else if (k == LAST)     state_nx = S_DONE;
            end
            S_CORR:   state_nx = S_DONE;
            S_DONE:   if (out_ready) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcv        <= '0;
            r          <= '0;
            p          <= '0;
            cnt        <= '0;
            k          <= '0;
            pow        <= '0;
            neg        <= 1'b0;
            out_cw     <= '0;
            out_awe    <= '0;
            out_rem    <= '0;
            out_err    <= 1'b0;
            out_uncorr <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        rcv <= in_cw;
                        r   <= '0;
                        cnt <= LAST;
                    end
                end
                S_REM: begin
                    r   <= r_step;
                    cnt <= cnt - 1'b1;
                end
                S_CHECK: begin
                    if (r == '0) begin
                        out_cw     <= rcv;
                        out_awe    <= '0;
                        out_rem    <= r;
                        out_err    <= 1'b0;
                        out_uncorr <= 1'b0;
                    end else begin
                        k   <= '0;
                        p   <= {{(A_W-1){1'b0}}, 1'b1};
                        pow <= {{(CW_W-1){1'b0}}, 1'b1};
                        neg <= 1'b0;
                    end
                end
                S_SEARCH: begin
                    if (hit_pos || hit_neg) begin
                        neg <= hit_neg;
                    end else if (k == LAST) begin
                        out_cw     <= rcv;
                        out_awe    <= '0;
                        out_rem    <= r;
                        out_err    <= 1'b1;
                        out_uncorr <= 1'b1;
                    end else begin
                        k   <= k + 1'b1;
                        p   <= p_step;
                        pow <= pow << 1;
                    end
                end
                S_CORR: begin
                    out_rem <= r;
                    out_err <= 1'b1;
                    if (c_bad) begin
                        out_cw     <= rcv;
                        out_awe    <= '0;
                        out_uncorr <= 1'b1;
                    end else begin
                        out_cw     <= c[CW_W-1:0];
                        out_awe    <= awe_val;
                        out_uncorr <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_an_sec_decoder_seq.sv
// Scoreboard bench for an_sec_decoder_seq: default A=131/CW_W=65 instance plus a
// small A=31/CW_W=8 instance for the no-match path.
module tb_an_sec_decoder_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [64:0] in_cw = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [64:0] out_cw;
    logic [65:0] out_awe;
    logic [7:0]  out_rem;
    logic        out_err;
    logic        out_uncorr;

    logic        s_in_valid = 1'b0;
    logic        s_in_ready;
    logic [7:0]  s_in_cw = '0;
    logic        s_out_valid;
    logic [7:0]  s_out_cw;
    logic [8:0]  s_out_awe;
    logic [4:0]  s_out_rem;
    logic        s_out_err;
    logic        s_out_uncorr;

    int checks = 0;
    int failures = 0;
    longint cyc = 0;

    typedef struct packed {
        logic [64:0] cw;
        logic [65:0] awe;
        logic [7:0]  rem;
        logic        err;
        logic        uncorr;
        int          lat;
        longint      acc;
    } exp_t;

    exp_t q[$];

    an_sec_decoder_seq #(.CW_W(65), .A(131), .A_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_cw(in_cw),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_cw(out_cw), .out_awe(out_awe), .out_rem(out_rem),
        .out_err(out_err), .out_uncorr(out_uncorr)
    );

    an_sec_decoder_seq #(.CW_W(8), .A(31), .A_W(5)) dut_s (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_cw(s_in_cw),
        .out_valid(s_out_valid), .out_ready(1'b1),
        .out_cw(s_out_cw), .out_awe(s_out_awe), .out_rem(s_out_rem),
        .out_err(s_out_err), .out_uncorr(s_out_uncorr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: compares the first cycle of each out_valid pulse against the queue head.
    bit seen = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!out_valid) begin
            seen = 1'b0;
        end else if (!seen) begin
            seen = 1'b1;
            if (q.size() == 0) begin
                chk("unexpected_output", 66'(out_valid), 66'(0));
            end else begin
                e = q.pop_front();
                chk("out_cw", 66'(out_cw), 66'(e.cw));
                chk("out_awe", out_awe, e.awe);
                chk("out_rem", 66'(out_rem), 66'(e.rem));
                chk("out_err", 66'(out_err), 66'(e.err));
                chk("out_uncorr", 66'(out_uncorr), 66'(e.uncorr));
                chk("latency", 66'(cyc - e.acc), 66'(e.lat));
            end
        end
    end

    // Called at a negedge; returns at a negedge.
    task automatic issue(input logic [64:0] cw, input logic [65:0] awe, input logic [7:0] rem,
                         input logic err, input logic unc, input int lat, input bit push);
        exp_t e;
        int n = 0;
        while (!in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 66'(in_ready), 66'(1));
        in_cw    = cw;
        in_valid = 1'b1;
        e.cw = cw - awe[64:0]; e.awe = awe; e.rem = rem; e.err = err; e.uncorr = unc;
        e.lat = lat; e.acc = cyc + 1;
        if (unc) e.cw = cw;
        if (push) q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        logic [64:0] base;
        logic [64:0] cw;
        logic [64:0] m;
        logic [65:0] pk;
        longint sacc;
        int n;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 66'(in_ready), 66'(1));
        chk("rst_out_valid", 66'(out_valid), 66'(0));
        chk("rst_out_cw", 66'(out_cw), 66'(0));
        chk("rst_out_awe", out_awe, 66'(0));
        chk("rst_status", 66'({out_rem, out_err, out_uncorr}), 66'(0));
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors
        issue(65'd655, 66'd0, 8'd0, 1'b0, 1'b0, 66, 1'b1);
        issue(65'd663, 66'd8, 8'd8, 1'b1, 1'b0, 71, 1'b1);
        issue(65'd527, -66'sd128, 8'd3, 1'b1, 1'b0, 75, 1'b1);
        issue(65'd125, 66'd0, 8'd125, 1'b1, 1'b1, 76, 1'b1);

        // Sweep of single AWEs on 131*12345
        base = 65'd1617195;
        for (int k = 0; k < 65; k++) begin
            pk = 66'd1 << k;
            cw = base + pk[64:0];
            m  = cw % 65'd131;
            issue(cw, pk, m[7:0], 1'b1, 1'b0, 68 + k, 1'b1);
        end
        for (int k = 0; k <= 20; k++) begin
            pk = 66'd1 << k;
            cw = base - pk[64:0];
            m  = cw % 65'd131;
            issue(cw, -pk, m[7:0], 1'b1, 1'b0, 68 + k, 1'b1);
        end

        // Back-pressure: result held while out_ready is low
        n = 0;
        while (!in_ready && n < 1000) begin @(negedge clk); n++; end
        out_ready = 1'b0;
        issue(65'd663, 66'd8, 8'd8, 1'b1, 1'b0, 71, 1'b1);
        n = 0;
        while (!out_valid && n < 200) begin @(negedge clk); n++; end
        chk("hold_reached_valid", 66'(out_valid), 66'(1));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_out_valid", 66'(out_valid), 66'(1));
            chk("hold_in_ready", 66'(in_ready), 66'(0));
            chk("hold_out_cw", 66'(out_cw), 66'(655));
            chk("hold_out_awe", out_awe, 66'(8));
        end
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("release_in_ready", 66'(in_ready), 66'(1));
        chk("release_out_valid", 66'(out_valid), 66'(0));

        // Reset during REM aborts without a result
        issue(65'd663, 66'd8, 8'd8, 1'b1, 1'b0, 71, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_in_ready", 66'(in_ready), 66'(1));
        chk("abort_out_valid", 66'(out_valid), 66'(0));
        chk("abort_out_cw", 66'(out_cw), 66'(0));
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        chk("abort_no_result", 66'(n), 66'(0));

        // Small instance: A=31, CW_W=8, in_cw=3 has no single-AWE match
        s_in_cw    = 8'd3;
        s_in_valid = 1'b1;
        sacc       = cyc + 1;
        @(negedge clk);
        s_in_valid = 1'b0;
        n = 0;
        while (!s_out_valid && n < 200) begin @(negedge clk); n++; end
        chk("small_latency", 66'(cyc - sacc), 66'(17));
        chk("small_uncorr", 66'(s_out_uncorr), 66'(1));
        chk("small_err", 66'(s_out_err), 66'(1));
        chk("small_awe", 66'(s_out_awe), 66'(0));
        chk("small_cw", 66'(s_out_cw), 66'(3));
        chk("small_rem", 66'(s_out_rem), 66'(3));

        n = 0;
        while (q.size() != 0 && n < 1000) begin @(negedge clk); n++; end
        chk("scoreboard_drained", 66'(q.size()), 66'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
